// File: rtl/rob_pkg.sv
// Shared definitions for the ROB commit controller: commit-word field layout,
// entry type codes and controller FSM states.
package rob_pkg;

  // Commit word layout delivered by the entry bank at the head index
  localparam int unsigned COMMIT_W    = 79;
  localparam int unsigned VALUE_LSB   = 0;
  localparam int unsigned VALUE_MSB   = 63;
  localparam int unsigned DONE_BIT    = 64;
  localparam int unsigned FLAGS_LSB   = 65;
  localparam int unsigned FLAGS_MSB   = 68;
  localparam int unsigned FLAGS_V_BIT = 69;
  localparam int unsigned AREG_LSB    = 70;
  localparam int unsigned AREG_MSB    = 74;
  localparam int unsigned TYPE_LSB    = 75;
  localparam int unsigned TYPE_MSB    = 78;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned AREG_W  = 5;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned TYPE_W  = 4;

  // Entry type codes; unlisted encodings retire as NOP
  typedef enum logic [TYPE_W-1:0] {
    T_NOP      = 4'd0,
    T_REG      = 4'd1,
    T_BRANCH   = 4'd2,
    T_STORE    = 4'd3,
    T_FLAGS    = 4'd4,
    T_REGFLAGS = 4'd5,
    T_HALT     = 4'd15
  } rob_type_e;

  // Controller state
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } rob_state_e;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer: increments modulo 2**W, synchronous clear and reset.
module rob_ptr_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] r_ptr;

  // Pointer register; natural W-bit overflow gives the modulo wrap
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: owns head/tail/count, grants tail entries to decode,
// retires the head in program order and drives architectural writes and the
// per-entry clears of the entry bank.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned ROBsize  = 16,
  parameter int unsigned addrSize = $clog2(ROBsize)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  alloc_req_i,
  output logic                  alloc_ready_o,
  output logic                  alloc_fire_o,
  output logic [addrSize-1:0]   alloc_tag_o,
  output logic [addrSize-1:0]   commit_addr_o,
  input  logic [COMMIT_W-1:0]   commit_data_i,
  input  logic [XLEN-1:0]       commit_extra_i,
  output logic [ROBsize-1:0]    rob_resets_o,
  output logic                  rf_we_o,
  output logic [AREG_W-1:0]     rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  flags_we_o,
  output logic [FLAGS_W-1:0]    flags_o,
  output logic                  st_we_o,
  output logic [XLEN-1:0]       st_addr_o,
  output logic [XLEN-1:0]       st_data_o,
  output logic                  flush_o,
  output logic                  halted_o,
  output logic [addrSize:0]     count_o
);

  localparam int unsigned CNT_W = addrSize + 1;

  rob_state_e            r_state;
  rob_state_e            w_state_nxt;
  logic [addrSize-1:0]   w_head;
  logic [addrSize-1:0]   w_tail;
  logic [CNT_W-1:0]      r_count;
  logic [TYPE_W-1:0]     w_type;
  logic                  w_run;
  logic                  w_in_flush;
  logic                  w_need_fv;
  logic                  w_commit_fire;
  logic                  w_mispredict;
  logic                  w_halt;
  logic [ROBsize-1:0]    w_head_onehot;

  // Decode of the head entry and the fire conditions
  assign w_type        = commit_data_i[TYPE_MSB:TYPE_LSB];
  assign w_run         = (r_state == ST_RUN) & ~reset_i;
  assign w_in_flush    = (r_state == ST_FLUSH);
  assign w_need_fv     = (w_type == T_FLAGS) | (w_type == T_REGFLAGS);
  assign w_commit_fire = w_run & (r_count != '0) & commit_data_i[DONE_BIT]
                       & (~w_need_fv | commit_data_i[FLAGS_V_BIT]);
  assign w_mispredict  = w_commit_fire & (w_type == T_BRANCH) & commit_data_i[VALUE_LSB];
  assign w_halt        = w_commit_fire & (w_type == T_HALT);

  // Ready ignores a same-cycle commit so the commit path stays out of ready
  assign alloc_ready_o = w_run & (r_count < CNT_W'(ROBsize));
  assign alloc_fire_o  = alloc_req_i & alloc_ready_o;
  assign alloc_tag_o   = w_tail;
  assign commit_addr_o = w_head;
  assign count_o       = r_count;
  assign w_head_onehot = ROBsize'(1) << w_head;

  rob_ptr_ctr #(.W(addrSize)) u_head (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_in_flush),
    .inc_i   (w_commit_fire),
    .ptr_o   (w_head)
  );

  rob_ptr_ctr #(.W(addrSize)) u_tail (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_in_flush),
    .inc_i   (alloc_fire_o),
    .ptr_o   (w_tail)
  );

  // Occupancy: +alloc -commit, emptied by a flush
  always_ff @(posedge clk_i) begin
    if (reset_i || w_in_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(alloc_fire_o) - CNT_W'(w_commit_fire);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: mispredict -> one flush cycle, HALT sticks until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mispredict) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_halt) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_FLUSH:  w_state_nxt = ST_RUN;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: architectural writes for the retiring entry and entry clears
  always_comb begin
    rf_we_o      = 1'b0;
    flags_we_o   = 1'b0;
    st_we_o      = 1'b0;
    rf_waddr_o   = commit_data_i[AREG_MSB:AREG_LSB];
    rf_wdata_o   = commit_data_i[VALUE_MSB:VALUE_LSB];
    flags_o      = commit_data_i[FLAGS_MSB:FLAGS_LSB];
    st_addr_o    = commit_extra_i;
    st_data_o    = commit_data_i[VALUE_MSB:VALUE_LSB];
    flush_o      = w_in_flush & ~reset_i;
    halted_o     = (r_state == ST_HALTED) & ~reset_i;
    rob_resets_o = '0;

    if (w_commit_fire) begin
      case (w_type)
        T_REG:      rf_we_o = 1'b1;
        T_STORE:    st_we_o = 1'b1;
        T_FLAGS:    flags_we_o = 1'b1;
        T_REGFLAGS: begin
          rf_we_o    = 1'b1;
          flags_we_o = 1'b1;
        end
        default: ;
      endcase
    end

    if (reset_i || w_in_flush) begin
      rob_resets_o = '1;
    end else if (w_commit_fire) begin
      rob_resets_o = w_head_onehot;
    end
  end

endmodule
